// File: rtl/mem_loader.sv
// ---------------------------------------------------------------------------
// mem_loader
//
// Host-side initiator for the CPU's external memory ports. A host issues
// commands on a valid/ready stream. The block can load words into
// instruction or data memory, run the core for a programmed number of
// cycles, or dump data memory back out on an output stream.
//
// Ports
//   clk, rst                      : clock, synchronous active-high reset
//   cmd_valid/cmd_ready           : command handshake
//   cmd_op                        : 0 LOAD_I, 1 LOAD_D, 2 RUN, 3 DUMP_D
//   cmd_addr                      : start byte address (unused for RUN)
//   cmd_len                       : word count (load/dump) or cycle count (RUN)
//   in_valid/in_ready/in_data     : load data stream (LOAD_I uses [31:0])
//   out_valid/out_ready/out_data  : dump data stream
//   busy                          : high whenever not IDLE
//   done                          : one-cycle pulse on command completion
//   enable                        : CPU run enable
//   addr_ext/wen_ext/ren_ext/wdata_ext/rdata_ext           : instruction memory
//   addr_ext_2/wen_ext_2/ren_ext_2/wdata_ext_2/rdata_ext_2 : data memory
// ---------------------------------------------------------------------------
module mem_loader #(
    parameter int IMEM_STRIDE = 4,
    parameter int DMEM_STRIDE = 8,
    parameter int LEN_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [63:0]      cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_data,
    output logic             busy,
    output logic             done,
    output logic             enable,
    output logic [63:0]      addr_ext,
    output logic             wen_ext,
    output logic             ren_ext,
    output logic [31:0]      wdata_ext,
    input  logic [31:0]      rdata_ext,
    output logic [63:0]      addr_ext_2,
    output logic             wen_ext_2,
    output logic             ren_ext_2,
    output logic [63:0]      wdata_ext_2,
    input  logic [63:0]      rdata_ext_2
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD_I  = 3'd1,
        S_LOAD_D  = 3'd2,
        S_RUN     = 3'd3,
        S_RD_REQ  = 3'd4,
        S_RD_WAIT = 3'd5,
        S_RD_OUT  = 3'd6,
        S_FIN     = 3'd7
    } state_t;

    localparam logic [LEN_W-1:0] CNT_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] CNT_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [63:0]      I_STEP   = 64'(IMEM_STRIDE);
    localparam logic [63:0]      D_STEP   = 64'(DMEM_STRIDE);

    state_t           state_r;
    state_t           next_state_s;
    logic [63:0]      addr_q;
    logic [63:0]      addr_next_s;
    logic [LEN_W-1:0] cnt_r;
    logic [LEN_W-1:0] cnt_next_s;
    logic [63:0]      out_data_r;
    logic [63:0]      out_data_next_s;

    logic        cmd_ready_s;
    logic        in_ready_s;
    logic        out_valid_s;
    logic        done_s;
    logic        enable_s;
    logic [63:0] addr_ext_s;
    logic        wen_ext_s;
    logic [31:0] wdata_ext_s;
    logic [63:0] addr_ext_2_s;
    logic        wen_ext_2_s;
    logic        ren_ext_2_s;
    logic [63:0] wdata_ext_2_s;

    // State, address, count and dump-data registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_IDLE;
            addr_q     <= 64'h0;
            cnt_r      <= CNT_ZERO;
            out_data_r <= 64'h0;
        end else begin
            state_r    <= next_state_s;
            addr_q     <= addr_next_s;
            cnt_r      <= cnt_next_s;
            out_data_r <= out_data_next_s;
        end
    end

    // Next-state, datapath updates and per-state port drive.
    always_comb begin
        next_state_s    = state_r;
        addr_next_s     = addr_q;
        cnt_next_s      = cnt_r;
        out_data_next_s = out_data_r;
        cmd_ready_s     = 1'b0;
        in_ready_s      = 1'b0;
        out_valid_s     = 1'b0;
        done_s          = 1'b0;
        enable_s        = 1'b0;
        addr_ext_s      = 64'h0;
        wen_ext_s       = 1'b0;
        wdata_ext_s     = 32'h0;
        addr_ext_2_s    = 64'h0;
        wen_ext_2_s     = 1'b0;
        ren_ext_2_s     = 1'b0;
        wdata_ext_2_s   = 64'h0;

        case (state_r)
            S_IDLE: begin
                cmd_ready_s = 1'b1;
                if (cmd_valid) begin
                    addr_next_s = cmd_addr;
                    cnt_next_s  = cmd_len;
                    if (cmd_len == CNT_ZERO) begin
                        next_state_s = S_FIN;
                    end else begin
                        case (cmd_op)
                            2'd0:    next_state_s = S_LOAD_I;
                            2'd1:    next_state_s = S_LOAD_D;
                            2'd2:    next_state_s = S_RUN;
                            2'd3:    next_state_s = S_RD_REQ;
                            default: next_state_s = S_IDLE;
                        endcase
                    end
                end else begin
                    next_state_s = S_IDLE;
                end
            end

            S_LOAD_I: begin
                in_ready_s = 1'b1;
                addr_ext_s = addr_q;
                if (in_valid) begin
                    wen_ext_s   = 1'b1;
                    wdata_ext_s = in_data[31:0];
                    addr_next_s = addr_q + I_STEP;
                    cnt_next_s  = cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        next_state_s = S_FIN;
                    end else begin
                        next_state_s = S_LOAD_I;
                    end
                end else begin
                    next_state_s = S_LOAD_I;
                end
            end

            S_LOAD_D: begin
                in_ready_s   = 1'b1;
                addr_ext_2_s = addr_q;
                if (in_valid) begin
                    wen_ext_2_s   = 1'b1;
                    wdata_ext_2_s = in_data;
                    addr_next_s   = addr_q + D_STEP;
                    cnt_next_s    = cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        next_state_s = S_FIN;
                    end else begin
                        next_state_s = S_LOAD_D;
                    end
                end else begin
                    next_state_s = S_LOAD_D;
                end
            end

            S_RUN: begin
                // Leaving on cnt==1 gives exactly cmd_len enable cycles.
                enable_s   = 1'b1;
                cnt_next_s = cnt_r - CNT_ONE;
                if (cnt_r == CNT_ONE) begin
                    next_state_s = S_FIN;
                end else begin
                    next_state_s = S_RUN;
                end
            end

            S_RD_REQ: begin
                ren_ext_2_s  = 1'b1;
                addr_ext_2_s = addr_q;
                next_state_s = S_RD_WAIT;
            end

            S_RD_WAIT: begin
                // Data memory answers one cycle after the read strobe.
                out_data_next_s = rdata_ext_2;
                next_state_s    = S_RD_OUT;
            end

            S_RD_OUT: begin
                out_valid_s = 1'b1;
                if (out_ready) begin
                    addr_next_s = addr_q + D_STEP;
                    cnt_next_s  = cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        next_state_s = S_FIN;
                    end else begin
                        next_state_s = S_RD_REQ;
                    end
                end else begin
                    next_state_s = S_RD_OUT;
                end
            end

            S_FIN: begin
                done_s       = 1'b1;
                next_state_s = S_IDLE;
            end

            default: begin
                next_state_s = S_IDLE;
            end
        endcase
    end

    // Outputs are forced quiet while rst is high so an abandoned command
    // cannot issue a strobe in the reset cycle itself.
    assign cmd_ready   = cmd_ready_s & ~rst;
    assign in_ready    = in_ready_s & ~rst;
    assign out_valid   = out_valid_s & ~rst;
    assign out_data    = rst ? 64'h0 : out_data_r;
    assign busy        = (state_r != S_IDLE) & ~rst;
    assign done        = done_s & ~rst;
    assign enable      = enable_s & ~rst;
    assign addr_ext    = rst ? 64'h0 : addr_ext_s;
    assign wen_ext     = wen_ext_s & ~rst;
    assign ren_ext     = 1'b0;
    assign wdata_ext   = rst ? 32'h0 : wdata_ext_s;
    assign addr_ext_2  = rst ? 64'h0 : addr_ext_2_s;
    assign wen_ext_2   = wen_ext_2_s & ~rst;
    assign ren_ext_2   = ren_ext_2_s & ~rst;
    assign wdata_ext_2 = rst ? 64'h0 : wdata_ext_2_s;

    // Instruction memory is write-only from this block.
    logic unused_s;
    assign unused_s = ^rdata_ext;

endmodule

// File: tb/tb_mem_loader.sv
// ---------------------------------------------------------------------------
// tb_mem_loader
//
// Directed self-checking bench for mem_loader. Inputs are driven 1ns after
// the rising edge; outputs are sampled on the falling edge. A small data
// memory model answers reads with one cycle latency, and a negedge logger
// records every write/read strobe and done pulse for the scenario tasks.
// ---------------------------------------------------------------------------
module tb_mem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [63:0] cmd_addr;
    logic [15:0] cmd_len;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        busy;
    logic        done;
    logic        enable;
    logic [63:0] addr_ext;
    logic        wen_ext;
    logic        ren_ext;
    logic [31:0] wdata_ext;
    logic [31:0] rdata_ext;
    logic [63:0] addr_ext_2;
    logic        wen_ext_2;
    logic        ren_ext_2;
    logic [63:0] wdata_ext_2;
    logic [63:0] rdata_ext_2;

    int checks = 0;
    int errors = 0;

    logic [63:0]  dmem [0:31];
    logic [127:0] iw_q [$];
    logic [127:0] dw_q [$];
    logic [63:0]  ra_q [$];
    int           done_cnt = 0;

    mem_loader #(.IMEM_STRIDE(4), .DMEM_STRIDE(8), .LEN_W(16)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .done(done), .enable(enable),
        .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext),
        .wdata_ext(wdata_ext), .rdata_ext(rdata_ext),
        .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
        .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2)
    );

    always #5 clk = ~clk;

    // Data memory model with one cycle read latency.
    always @(posedge clk) begin
        if (wen_ext_2) dmem[addr_ext_2[7:3]] <= wdata_ext_2;
        if (ren_ext_2) rdata_ext_2 <= dmem[addr_ext_2[7:3]];
    end

    // Strobe and done logger.
    always @(negedge clk) begin
        if (wen_ext)   iw_q.push_back({addr_ext, 32'h0, wdata_ext});
        if (wen_ext_2) dw_q.push_back({addr_ext_2, wdata_ext_2});
        if (ren_ext_2) ra_q.push_back(addr_ext_2);
        if (done)      done_cnt = done_cnt + 1;
    end

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic clear_logs();
        iw_q.delete();
        dw_q.delete();
        ra_q.delete();
        done_cnt = 0;
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [63:0] a, input logic [15:0] len);
        cmd_op    = op;
        cmd_addr  = a;
        cmd_len   = len;
        cmd_valid = 1'b1;
        adv();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic any_s;
        rst = 1'b1; cmd_valid = 1'b1; cmd_op = 2'd2; cmd_addr = 64'h40; cmd_len = 16'd5;
        in_valid = 1'b1; in_data = 64'h1234; out_ready = 1'b1; rdata_ext = 32'h0;
        for (int i = 0; i < 2; i++) begin
            smp();
            any_s = |{cmd_ready, in_ready, out_valid, busy, done, enable, wen_ext, ren_ext,
                      wen_ext_2, ren_ext_2, addr_ext, wdata_ext, addr_ext_2, wdata_ext_2, out_data};
            checks++;
            if (any_s !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: some output nonzero (or-reduce=%b), required all 0", i, any_s);
            end
            adv();
        end
        rst = 1'b0; cmd_valid = 1'b0;
        smp();
        checks++;
        if ({cmd_ready, busy, in_ready, wen_ext, wen_ext_2, enable} !== 6'b100000) begin
            errors++;
            $display("FAIL after_reset: ready/busy/in_ready/wen/wen2/en=%b required 100000",
                     {cmd_ready, busy, in_ready, wen_ext, wen_ext_2, enable});
        end
        adv();
        in_valid = 1'b0;
    endtask

    task automatic test_load_i();
        logic [5:0]  vpat;
        logic [31:0] words [3];
        logic [127:0] exp;
        int k;
        vpat = 6'b100101;
        words[0] = 32'h00500093; words[1] = 32'h00a00113; words[2] = 32'h002081b3;
        clear_logs();
        send_cmd(2'd0, 64'h0, 16'd3);
        k = 0;
        for (int i = 0; i < 6; i++) begin
            in_valid = vpat[i];
            in_data  = vpat[i] ? {32'hFFFF0000, words[k]} : 64'hBAD0BAD0BAD0BAD0;
            smp();
            checks++;
            if (wen_ext !== vpat[i] || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL load_i_strobe cycle %0d: wen=%b in_ready=%b required wen=%b in_ready=1",
                         i, wen_ext, in_ready, vpat[i]);
            end
            if (vpat[i]) k++;
            adv();
        end
        in_valid = 1'b0;
        smp();
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL load_i_done: done=%b required 1", done);
        end
        adv();
        smp();
        checks++;
        if (done !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL load_i_idle: done=%b cmd_ready=%b required 0/1", done, cmd_ready);
        end
        checks++;
        if (iw_q.size() != 3 || done_cnt != 1) begin
            errors++;
            $display("FAIL load_i_count: writes=%0d done=%0d required 3/1", iw_q.size(), done_cnt);
        end
        for (int j = 0; j < 3 && j < iw_q.size(); j++) begin
            exp = {64'(4 * j), 32'h0, words[j]};
            checks++;
            if (iw_q[j] !== exp) begin
                errors++;
                $display("FAIL load_i_write%0d: got %h required %h", j, iw_q[j], exp);
            end
        end
    endtask

    task automatic test_load_dump();
        int n;
        clear_logs();
        send_cmd(2'd1, 64'h10, 16'd2);
        in_valid = 1'b1; in_data = 64'hDEADBEEF00000001;
        smp();
        checks++;
        if ({wen_ext_2, addr_ext_2, wdata_ext_2} !== {1'b1, 64'h10, 64'hDEADBEEF00000001}) begin
            errors++;
            $display("FAIL load_d_w0: wen2=%b addr=%h data=%h required 1/10/deadbeef00000001",
                     wen_ext_2, addr_ext_2, wdata_ext_2);
        end
        adv();
        in_data = 64'h2;
        smp();
        checks++;
        if ({wen_ext_2, addr_ext_2, wdata_ext_2} !== {1'b1, 64'h18, 64'h2}) begin
            errors++;
            $display("FAIL load_d_w1: wen2=%b addr=%h data=%h required 1/18/2",
                     wen_ext_2, addr_ext_2, wdata_ext_2);
        end
        adv();
        in_valid = 1'b0;
        smp();
        checks++;
        if (done !== 1'b1 || dw_q.size() != 2) begin
            errors++;
            $display("FAIL load_d_done: done=%b writes=%0d required 1/2", done, dw_q.size());
        end
        adv();

        clear_logs();
        out_ready = 1'b0;
        send_cmd(2'd3, 64'h10, 16'd2);
        n = 0;
        smp();
        while (out_valid !== 1'b1 && n < 10) begin adv(); smp(); n++; end
        checks++;
        if (n != 2 || out_data !== 64'hDEADBEEF00000001) begin
            errors++;
            $display("FAIL dump_first: latency=%0d data=%h required 2/deadbeef00000001", n, out_data);
        end
        for (int i = 0; i < 5; i++) begin
            adv();
            smp();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 64'hDEADBEEF00000001 || ren_ext_2 !== 1'b0) begin
                errors++;
                $display("FAIL dump_hold%0d: valid=%b data=%h ren2=%b required 1/deadbeef00000001/0",
                         i, out_valid, out_data, ren_ext_2);
            end
        end
        adv();
        out_ready = 1'b1;
        smp();
        adv();
        n = 0;
        smp();
        while (out_valid !== 1'b1 && n < 10) begin adv(); smp(); n++; end
        checks++;
        if (n != 2 || out_data !== 64'h2) begin
            errors++;
            $display("FAIL dump_second: latency=%0d data=%h required 2/2", n, out_data);
        end
        adv();
        smp();
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL dump_done: done=%b valid=%b required 1/0", done, out_valid);
        end
        adv();
        checks++;
        if (ra_q.size() != 2 || done_cnt != 1) begin
            errors++;
            $display("FAIL dump_reads: reads=%0d done=%0d required 2/1", ra_q.size(), done_cnt);
        end else begin
            checks++;
            if (ra_q[0] !== 64'h10 || ra_q[1] !== 64'h18) begin
                errors++;
                $display("FAIL dump_addr: got %h %h required 10 18", ra_q[0], ra_q[1]);
            end
        end
    endtask

    task automatic test_run();
        logic [9:0] en_bits;
        int done_at;
        clear_logs();
        en_bits = 10'h0;
        done_at = -1;
        send_cmd(2'd2, 64'hFFFF, 16'd7);
        for (int i = 1; i <= 9; i++) begin
            smp();
            en_bits[i] = enable;
            if (done === 1'b1 && done_at < 0) done_at = i;
            adv();
        end
        checks++;
        if (en_bits !== 10'b0011111110) begin
            errors++;
            $display("FAIL run_enable: cycles=%b required 0011111110", en_bits);
        end
        checks++;
        if (done_at != 8 || done_cnt != 1) begin
            errors++;
            $display("FAIL run_done: at=%0d count=%0d required 8/1", done_at, done_cnt);
        end
        checks++;
        if (iw_q.size() + dw_q.size() + ra_q.size() != 0) begin
            errors++;
            $display("FAIL run_strobes: %0d strobes required 0", iw_q.size() + dw_q.size() + ra_q.size());
        end
    endtask

    task automatic test_zero_len();
        logic [1:0] op;
        clear_logs();
        for (int i = 0; i < 4; i++) begin
            op = 2'(i);
            send_cmd(op, 64'h40, 16'd0);
            smp();
            checks++;
            if (done !== 1'b1 || enable !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL zero_len_op%0d: done=%b enable=%b busy=%b required 1/0/1", i, done, enable, busy);
            end
            adv();
            smp();
            checks++;
            if (cmd_ready !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL zero_len_idle%0d: cmd_ready=%b done=%b required 1/0", i, cmd_ready, done);
            end
        end
        checks++;
        if (iw_q.size() + dw_q.size() + ra_q.size() != 0 || done_cnt != 4) begin
            errors++;
            $display("FAIL zero_len_summary: strobes=%0d done=%0d required 0/4",
                     iw_q.size() + dw_q.size() + ra_q.size(), done_cnt);
        end
    endtask

    task automatic test_mid_reset();
        clear_logs();
        send_cmd(2'd0, 64'h100, 16'd4);
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_data = 64'(i + 1);
            adv();
        end
        in_data = 64'h3;
        rst = 1'b1;
        smp();
        checks++;
        if (wen_ext !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_cycle: wen=%b done=%b required 0/0", wen_ext, done);
        end
        adv();
        rst = 1'b0;
        in_valid = 1'b0;
        smp();
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || iw_q.size() != 2) begin
            errors++;
            $display("FAIL mid_reset_after: ready=%b busy=%b done=%b writes=%0d required 1/0/0/2",
                     cmd_ready, busy, done, iw_q.size());
        end
        send_cmd(2'd0, 64'h200, 16'd1);
        in_valid = 1'b1;
        in_data  = 64'hABCD;
        smp();
        adv();
        in_valid = 1'b0;
        smp();
        adv();
        checks++;
        if (iw_q.size() != 3 || done_cnt != 1) begin
            errors++;
            $display("FAIL mid_reset_reload_count: writes=%0d done=%0d required 3/1", iw_q.size(), done_cnt);
        end else begin
            checks++;
            if (iw_q[2] !== {64'h200, 32'h0, 32'h0000ABCD}) begin
                errors++;
                $display("FAIL mid_reset_reload: got %h required addr 200 data abcd", iw_q[2]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) dmem[i] = 64'h0;
        rdata_ext_2 = 64'h0;
        test_reset();
        test_load_i();
        test_load_dump();
        test_run();
        test_zero_len();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
